// File: rtl/nfsr_stream_checker.sv
// Receive-side NFSR keystream checker: runs a local copy of the 24-bit NFSR
// seeded like the generator, compares each qualified serial bit against the
// expected keystream, and reports pass/fail per frame or aborts on an error burst.
module nfsr_stream_checker #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ERR_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Par_load,
  input  logic [23:0]      Seed,
  input  logic             shift_en,
  input  logic             Ser_in,
  output logic [23:0]      Rx_word,
  output logic [CNT_W-1:0] Bit_cnt,
  output logic [CNT_W-1:0] Err_cnt,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic             Abort
);

  localparam int unsigned SEED_W   = 24;
  localparam int unsigned CONSEC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SEED_W-1:0]   nfsr_q;
  logic [CONSEC_W-1:0] consec_q;

  logic                consume_c;
  logic                mismatch_c;
  logic                feedback_c;
  logic [CNT_W-1:0]    bit_cnt_inc_c;
  logic [CNT_W-1:0]    err_cnt_nxt_c;
  logic [CONSEC_W-1:0] consec_inc_c;
  logic                hit_limit_c;
  logic                frame_end_c;

  // Per-bit compare and counter arithmetic; a bit is only consumed in CHECK and Par_load wins.
  always_comb begin
    consume_c     = (state == ST_CHECK) && shift_en && !Par_load;
    mismatch_c    = Ser_in ^ nfsr_q[23];
    feedback_c    = nfsr_q[23] ^ nfsr_q[18] ^ nfsr_q[12] ^ nfsr_q[4]
                  ^ (nfsr_q[20] & nfsr_q[9]) ^ (nfsr_q[15] & nfsr_q[2]);
    bit_cnt_inc_c = CNT_W'(Bit_cnt + CNT_W'(1));
    err_cnt_nxt_c = Err_cnt;
    if (mismatch_c && (Err_cnt != {CNT_W{1'b1}})) begin
      err_cnt_nxt_c = CNT_W'(Err_cnt + CNT_W'(1));
    end
    consec_inc_c  = CONSEC_W'(consec_q + CONSEC_W'(1));
    hit_limit_c   = consume_c && mismatch_c && (consec_inc_c == CONSEC_W'(ERR_LIMIT));
    frame_end_c   = consume_c && (bit_cnt_inc_c == CNT_W'(FRAME_LEN));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: Par_load (re)starts a frame from any state.
  always_comb begin
    state_nxt = state;
    if (Par_load) begin
      state_nxt = ST_CHECK;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_CHECK: if (hit_limit_c || frame_end_c) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the state register.
  always_comb begin
    Busy = (state == ST_CHECK);
  end

  // Datapath: local NFSR, receive window, counters and end-of-frame flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      nfsr_q   <= '0;
      consec_q <= '0;
      Rx_word  <= '0;
      Bit_cnt  <= '0;
      Err_cnt  <= '0;
      Done     <= 1'b0;
      Pass     <= 1'b0;
      Abort    <= 1'b0;
    end else if (Par_load) begin
      nfsr_q   <= Seed;
      consec_q <= '0;
      Rx_word  <= '0;
      Bit_cnt  <= '0;
      Err_cnt  <= '0;
      Done     <= 1'b0;
      Pass     <= 1'b0;
      Abort    <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (consume_c) begin
        nfsr_q   <= {nfsr_q[22:0], feedback_c};
        Rx_word  <= {Rx_word[22:0], Ser_in};
        Bit_cnt  <= bit_cnt_inc_c;
        Err_cnt  <= err_cnt_nxt_c;
        consec_q <= mismatch_c ? consec_inc_c : '0;
      end
      // The burst abort takes priority over a normal frame end on the same bit.
      if (hit_limit_c) begin
        Done  <= 1'b1;
        Abort <= 1'b1;
        Pass  <= 1'b0;
      end else if (frame_end_c) begin
        Done  <= 1'b1;
        Pass  <= (err_cnt_nxt_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_nfsr_stream_checker.sv
// Bench for nfsr_stream_checker: two instances (24- and 64-bit frames) share
// stimulus; expectations come from a keystream recurrence and frame counting model.
module tb_nfsr_stream_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        Par_load;
  logic [23:0] Seed;
  logic        shift_en;
  logic        Ser_in;

  logic [23:0] rx24, rx64;
  logic [15:0] bc24, ec24, bc64, ec64;
  logic        busy24, done24, pass24, abort24;
  logic        busy64, done64, pass64, abort64;

  int checks = 0;
  int errors = 0;
  bit ks [0:255];

  always #5 clk = ~clk;

  nfsr_stream_checker #(.FRAME_LEN(24), .CNT_W(16), .ERR_LIMIT(8)) dut24 (
    .clk(clk), .rst(rst), .Par_load(Par_load), .Seed(Seed), .shift_en(shift_en),
    .Ser_in(Ser_in), .Rx_word(rx24), .Bit_cnt(bc24), .Err_cnt(ec24), .Busy(busy24),
    .Done(done24), .Pass(pass24), .Abort(abort24)
  );

  nfsr_stream_checker #(.FRAME_LEN(64), .CNT_W(16), .ERR_LIMIT(8)) dut64 (
    .clk(clk), .rst(rst), .Par_load(Par_load), .Seed(Seed), .shift_en(shift_en),
    .Ser_in(Ser_in), .Rx_word(rx64), .Bit_cnt(bc64), .Err_cnt(ec64), .Busy(busy64),
    .Done(done64), .Pass(pass64), .Abort(abort64)
  );

  // Keystream as a bit sequence: seed MSB-first, then the generator recurrence.
  task automatic make_ks(input logic [23:0] s);
    for (int i = 0; i < 24; i++) ks[i] = s[23-i];
    for (int n = 0; n + 24 < 256; n++) begin
      ks[n+24] = ks[n] ^ ks[n+5] ^ ks[n+11] ^ ks[n+19]
               ^ (ks[n+3] & ks[n+14]) ^ (ks[n+8] & ks[n+21]);
    end
  endtask

  // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic pl, input logic se, input logic si);
    @(negedge clk);
    Par_load = pl;
    shift_en = se;
    Ser_in   = si;
    @(posedge clk);
    #1;
    Par_load = 1'b0;
    shift_en = 1'b0;
  endtask

  task automatic gaps();
    repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++;
    if ({rx24, bc24, ec24, busy24, done24, pass24, abort24} !== '0) begin
      errors++;
      $display("FAIL reset24 got rx=%h bc=%0d ec=%0d b/d/p/a=%b%b%b%b exp all zero",
               rx24, bc24, ec24, busy24, done24, pass24, abort24);
    end
    checks++;
    if ({rx64, bc64, ec64, busy64, done64, pass64, abort64} !== '0) begin
      errors++;
      $display("FAIL reset64 got rx=%h bc=%0d ec=%0d exp all zero", rx64, bc64, ec64);
    end
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if ({bc24, busy24} !== '0) begin
      errors++;
      $display("FAIL idle_ignores_shift got bc=%0d busy=%b exp 0 0", bc24, busy24);
    end
  endtask

  // Drive a 24-bit frame of the seed bits, optionally inverting one bit position.
  task automatic run_seed_frame(input logic [23:0] s, input int flip_idx, input string tag);
    logic [15:0] exp_ec;
    logic [23:0] exp_rx;
    bit          early;
    exp_ec = (flip_idx >= 0) ? 16'd1 : 16'd0;
    exp_rx = s;
    if (flip_idx >= 0) exp_rx[23-flip_idx] = ~s[23-flip_idx];
    early = 1'b0;
    Seed = s;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (busy24 !== 1'b1 || bc24 !== 16'd0) begin
      errors++;
      $display("FAIL %s_load got busy=%b bc=%0d exp 1 0", tag, busy24, bc24);
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b1, s[23-i] ^ (i == flip_idx));
      if (i < 23 && done24 !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL %s_early_done got 1 exp 0 before bit 24", tag);
    end
    checks++;
    if ({done24, pass24, abort24, busy24} !== {1'b1, (flip_idx < 0), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s_flags got d/p/a/b=%b%b%b%b exp %b%b%b%b", tag, done24, pass24,
               abort24, busy24, 1'b1, (flip_idx < 0), 1'b0, 1'b0);
    end
    checks++;
    if (bc24 !== 16'd24 || ec24 !== exp_ec || rx24 !== exp_rx) begin
      errors++;
      $display("FAIL %s_counts got bc=%0d ec=%0d rx=%h exp 24 %0d %h", tag, bc24, ec24,
               rx24, exp_ec, exp_rx);
    end
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (done24 !== 1'b0 || pass24 !== (flip_idx < 0) || bc24 !== 16'd24 || rx24 !== exp_rx) begin
      errors++;
      $display("FAIL %s_hold got done=%b pass=%b bc=%0d rx=%h exp 0 %b 24 %h", tag, done24,
               pass24, bc24, rx24, (flip_idx < 0), exp_rx);
    end
  endtask

  task automatic test_clean_frame();
    run_seed_frame(24'habcdef, -1, "clean");
  endtask

  task automatic test_single_error();
    run_seed_frame(24'habcdef, 5, "bit6err");
  endtask

  task automatic test_generator_64();
    logic [23:0] exp_rx;
    bit          early;
    make_ks(24'habcdef);
    Seed = 24'habcdef;
    early = 1'b0;
    exp_rx = '0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      gaps();
      step(1'b0, 1'b1, ks[i]);
      exp_rx = {exp_rx[22:0], ks[i]};
      if (i < 63 && done64 !== 1'b0) early = 1'b1;
      if (i == 23) begin
        checks++;
        if (done24 !== 1'b1 || pass24 !== 1'b1) begin
          errors++;
          $display("FAIL gen24_pass got done=%b pass=%b exp 1 1", done24, pass24);
        end
      end
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL gen64_early_done got 1 exp 0 before bit 64");
    end
    checks++;
    if ({done64, pass64, abort64} !== 3'b110 || ec64 !== 16'd0 || bc64 !== 16'd64) begin
      errors++;
      $display("FAIL gen64_end got d/p/a=%b%b%b ec=%0d bc=%0d exp 110 0 64", done64, pass64,
               abort64, ec64, bc64);
    end
    checks++;
    if (rx64 !== exp_rx) begin
      errors++;
      $display("FAIL gen64_rx got %h exp %h", rx64, exp_rx);
    end
  endtask

  task automatic test_abort();
    logic [23:0] s;
    bit          early;
    s = 24'($urandom);
    make_ks(s);
    Seed = s;
    early = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, ks[i] ^ (i >= 2));
      if (i < 9 && (done24 !== 1'b0 || abort24 !== 1'b0)) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL abort_early got done/abort before bit 10 exp none");
    end
    checks++;
    if ({done24, abort24, pass24} !== 3'b110 || ec24 !== 16'd8 || bc24 !== 16'd10) begin
      errors++;
      $display("FAIL abort24 got d/a/p=%b%b%b ec=%0d bc=%0d exp 110 8 10", done24, abort24,
               pass24, ec24, bc24);
    end
    checks++;
    if ({done64, abort64} !== 2'b11 || ec64 !== 16'd8) begin
      errors++;
      $display("FAIL abort64 got d/a=%b%b ec=%0d exp 11 8", done64, abort64, ec64);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (done24 !== 1'b0 || abort24 !== 1'b1 || bc24 !== 16'd10) begin
      errors++;
      $display("FAIL abort_hold got done=%b abort=%b bc=%0d exp 0 1 10", done24, abort24, bc24);
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] s;
    s = 24'($urandom);
    make_ks(s);
    Seed = s;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, ks[i]);
    checks++;
    if (bc24 !== 16'd10) begin
      errors++;
      $display("FAIL midrst_pre got bc=%0d exp 10", bc24);
    end
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    checks++;
    if ({rx24, bc24, ec24, busy24, done24, pass24, abort24} !== '0) begin
      errors++;
      $display("FAIL midrst_clear got rx=%h bc=%0d ec=%0d busy=%b exp all zero", rx24, bc24,
               ec24, busy24);
    end
    step(1'b1, 1'b1, ks[0]);
    checks++;
    if (bc24 !== 16'd0 || busy24 !== 1'b1 || done24 !== 1'b0) begin
      errors++;
      $display("FAIL load_wins got bc=%0d busy=%b done=%b exp 0 1 0", bc24, busy24, done24);
    end
    step(1'b0, 1'b1, ks[0]);
    checks++;
    if (bc24 !== 16'd1 || ec24 !== 16'd0 || rx24 !== {23'd0, ks[0]}) begin
      errors++;
      $display("FAIL first_bit got bc=%0d ec=%0d rx=%h exp 1 0 %h", bc24, ec24, rx24,
               {23'd0, ks[0]});
    end
  endtask

  task automatic test_restart_gaps();
    logic [23:0] s;
    bit          early;
    s = 24'($urandom);
    make_ks(s);
    Seed = s;
    early = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      gaps();
      step(1'b0, 1'b1, ks[i]);
    end
    checks++;
    if (bc24 !== 16'd12) begin
      errors++;
      $display("FAIL restart_pre got bc=%0d exp 12", bc24);
    end
    s = 24'($urandom);
    make_ks(s);
    Seed = s;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (bc24 !== 16'd0 || done24 !== 1'b0 || busy24 !== 1'b1) begin
      errors++;
      $display("FAIL restart got bc=%0d done=%b busy=%b exp 0 0 1", bc24, done24, busy24);
    end
    for (int i = 0; i < 24; i++) begin
      gaps();
      step(1'b0, 1'b1, ks[i]);
      if (i < 23 && done24 !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early || {done24, pass24, abort24} !== 3'b110 || ec24 !== 16'd0) begin
      errors++;
      $display("FAIL restart_frame got early=%b d/p/a=%b%b%b ec=%0d exp 0 110 0", early,
               done24, pass24, abort24, ec24);
    end
  endtask

  // Random seeds and error rates against a bit-by-bit frame counting model.
  task automatic test_random_frames();
    int          rates [4] = '{0, 5, 40, 90};
    logic [23:0] s;
    int          m_err, m_consec, m_n;
    bit          m_abort, m_end, flip, bad;
    for (int f = 0; f < 8; f++) begin
      s = 24'($urandom);
      make_ks(s);
      Seed = s;
      step(1'b1, 1'b0, 1'b0);
      m_err = 0; m_consec = 0; m_n = 0; m_abort = 0; m_end = 0; bad = 0;
      while (!m_end) begin
        gaps();
        flip = ($urandom_range(0, 99) < rates[f % 4]);
        step(1'b0, 1'b1, ks[m_n] ^ flip);
        m_n++;
        if (flip) begin
          m_err++;
          m_consec++;
        end else begin
          m_consec = 0;
        end
        if (m_consec == 8) begin
          m_abort = 1;
          m_end = 1;
        end else if (m_n == 24) begin
          m_end = 1;
        end
        if (bc24 !== 16'(m_n) || ec24 !== 16'(m_err) || done24 !== m_end) bad = 1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL rand%0d_counts got bc=%0d ec=%0d done=%b exp %0d %0d 1", f, bc24, ec24,
                 done24, m_n, m_err);
      end
      checks++;
      if (abort24 !== m_abort || pass24 !== (!m_abort && m_err == 0)) begin
        errors++;
        $display("FAIL rand%0d_result got abort=%b pass=%b exp %b %b", f, abort24, pass24,
                 m_abort, (!m_abort && m_err == 0));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    Par_load = 1'b0;
    shift_en = 1'b0;
    Ser_in = 1'b0;
    Seed = '0;
    test_reset();
    test_clean_frame();
    test_single_error();
    test_generator_64();
    test_abort();
    test_mid_reset();
    test_restart_gaps();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
